// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus responder.
// Optional statistics counters: define MEM_BUS_STATS_EN.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } resp_state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } mem_op_t;

  localparam int WAIT_CYCLES_DEF = 2;
  localparam int CNT_W = 4;
  localparam int STAT_W = 16;

endpackage

// File: rtl/mem_bus_array.sv
// Single-port synchronous word storage; no reset so it maps onto RAM.
// Read data register only changes on a read access.
module mem_bus_array #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Fixed-latency memory responder for the CPU MAR/MBR bus.
// Optional rd/wr statistics counters: define MEM_BUS_STATS_EN.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 14,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef MEM_BUS_STATS_EN
  output logic [STAT_W-1:0]     rd_count,
  output logic [STAT_W-1:0]     wr_count,
`endif
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready,
  output logic                  busy,
  output logic                  err
);

  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  resp_state_t           state;
  mem_op_t               op_q;
  mem_op_t               op_in;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [CNT_W-1:0]      cnt;
  logic                  capture;
  logic                  go_done;
  logic                  rd_valid;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign capture = (state == IDLE) && cs && (we || oe);
  assign op_in   = we ? OP_WR : OP_RD;

  // Storage is accessed on the edge that enters DONE, so a zero-wait
  // request must steer the live bus straight into the array.
  always_comb begin
    go_done   = 1'b0;
    mem_we    = (op_q == OP_WR);
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    unique case (1'b1)
      (state == IDLE): begin
        go_done   = capture && (WAIT_CYCLES == 0);
        mem_we    = (op_in == OP_WR);
        mem_addr  = addr;
        mem_wdata = wdata;
      end
      (state == WAIT): go_done = (cnt == '0);
      default:         go_done = 1'b0;
    endcase
  end

  mem_bus_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk  (clk),
    .en   (go_done),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= OP_RD;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt      <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      ready <= go_done;
      busy  <= capture || (state != IDLE);
      if (go_done && !mem_we) rd_valid <= 1'b1;
      unique case (state)
        IDLE: begin
          if (capture) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            op_q    <= op_in;
            cnt     <= CNT_INIT;
            if (we && oe) err <= 1'b1;
            state <= (WAIT_CYCLES > 0) ? WAIT : DONE;
          end
        end
        WAIT: begin
          if (cnt == '0) state <= DONE;
          else cnt <= cnt - 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Array read register has no reset; mask it until the first read lands.
  assign rdata = rd_valid ? mem_rdata : '0;

`ifdef MEM_BUS_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == DONE) begin
      if (op_q == OP_WR) begin
        if (wr_count != '1) wr_count <= wr_count + 1'b1;
      end else begin
        if (rd_count != '1) rd_count <= rd_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder for the CPU's MAR/MBR bus.
- Accepts single-word read/write requests (cs/we/oe) from the CPU sequencer, waits a fixed number of cycles and completes each request with a one-cycle ready pulse.
- Sits between the CPU datapath and the word storage. Replaces the zero-latency RAM so the CPU fetch/execute sequencing can be made handshake-driven.

Parameters:
- ADDR_WIDTH, 14: word address width; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32: word width.
- WAIT_CYCLES, 2: cycles between request capture and ready; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- addr  input  ADDR_WIDTH  word address (the CPU's MAR).
- wdata  input  DATA_WIDTH  write data (the CPU's MBR).
- cs  input  1  request valid.
- we  input  1  write request.
- oe  input  1  read request.
- rdata  output  DATA_WIDTH  read data, registered.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  high from capture until the cycle after ready.
- err  output  1  sticky, set on an illegal request.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; rdata=0, ready=0, busy=0, err=0; wait counter=0.
  - Storage contents are not reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - When cs=1 and (we|oe)=1, capture addr, wdata and op on that edge; busy=1.
  - Next state is WAIT if WAIT_CYCLES>0, else DONE.
  - cs=1 with we=0 and oe=0 is ignored: no capture.
- WAIT:
  - Counter loads WAIT_CYCLES-1 on entry and decrements each cycle.
  - Go to DONE when the counter is 0.
- DONE (one cycle):
  - Write: mem[addr_q] <= wdata_q.
  - Read: rdata <= mem[addr_q].
  - ready=1 for exactly this cycle; the next state is IDLE.
- Latency: ready asserts WAIT_CYCLES+1 cycles after the capture edge. rdata is valid in the ready cycle.
- rdata holds its value until the next read completes; writes do not disturb it. oe does not gate rdata.
- busy deasserts in the cycle after ready. A new request is accepted only in IDLE, so there is a minimum one idle cycle between transactions.
- Inputs are ignored while busy, including cs dropping and addr/we/oe/wdata changes. A captured request always completes.
- we=1 and oe=1 together at capture: treated as a write, and err is set sticky until reset.
- Reset mid-transaction:
  - Returns to IDLE immediately and no ready is produced.
  - A pending write is discarded and memory is untouched.
- Address indexes words directly. The CPU's PC+2 stride is the initiator's concern.

Optional Feature:
- Macro: MEM_BUS_STATS_EN.
- Defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0], both reset to 0.
  - Each increments in the DONE cycle of its operation and saturates at 'hFFFF.
  - A we+oe request counts as a write.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package mem_bus_pkg holds:
  - enum resp_state_t {IDLE, WAIT, DONE};
  - enum mem_op_t {OP_RD, OP_WR};
  - localparam default WAIT_CYCLES and the counter width (4).
- One sub-module, mem_bus_array:
  - Synchronous single-port storage, parameterised ADDR_WIDTH/DATA_WIDTH.
  - Ports: clk, en, we, addr, wdata, rdata.
  - No reset, so it infers RAM.
- The FSM, capture registers and stats counters stay in mem_bus_responder.

Test Plan:
- Write then read, WAIT_CYCLES=2:
  - Write 'h1000011E to addr 'h100 -> ready pulses 3 cycles after capture, busy high 4 cycles.
  - Read 'h100 -> rdata='h1000011E in the ready cycle.
- Program load and readback:
  - Write the 18-word sequence 'h100..'h122 step 2, ending 'h78000001 at 'h122.
  - Read 'h11A -> 'h78000009; read 'h122 -> 'h78000001.
  - With MEM_BUS_STATS_EN: wr_count=18, rd_count=2.
- Hold and ignore:
  - Issue read 'h104 (holding 'h1800011C), then drop cs and change addr to 'h106 during WAIT.
  - Expect rdata='h1800011C.
  - A second request during busy is not captured: exactly one ready.
- Illegal and idle requests:
  - cs=1, we=1, oe=1, wdata='hDEADBEEF @ 'h11C -> err=1 and a write occurs; a read of 'h11C returns 'hDEADBEEF.
  - cs=1 with we=oe=0 -> no ready, busy stays 0.
- Reset mid-write:
  - Preload 'h120='h00000001, start write 'h55 @ 'h120, pulse rst_n low during WAIT.
  - Expect outputs to return to 0, no ready, and a subsequent read of 'h120 to return 'h00000001.
- WAIT_CYCLES=0 build:
  - Ready is 1 cycle after capture.
  - Back-to-back requests complete every 2 cycles.
